// File: rtl/csr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csr_pkg : shared types and constants for the CSR counter block       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_READ = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_COMMIT = 2'd2
    } csr_state_e;

    localparam logic [11:0] C_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] C_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] C_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] C_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] C_ADDR_MCOUNTINH = 12'h320;
    localparam logic [11:0] C_ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] C_ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] C_ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] C_ADDR_INSTRETH  = 12'hC82;

    localparam int C_INH_CY = 0;
    localparam int C_INH_IR = 2;

    // Set/clear with a zero mask is a pure read and never modifies state.
    function automatic logic is_write(input csr_op_e op, input logic [31:0] wdata);
        return (op == CSR_RW) || ((op != CSR_READ) && (wdata != 32'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_cnt64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csr_cnt64 : 64-bit counter with independently writable halves        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module csr_cnt64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);

    logic [63:0] cnt_q;

    // A write takes priority and swallows that cycle's increment (no carry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (wr_lo) begin
            cnt_q <= {cnt_q[63:32], wdata};
        end else if (wr_hi) begin
            cnt_q <= {wdata, cnt_q[31:0]};
        end else if (inc) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/csr_counter_wr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csr_counter_wr : mcycle/minstret/mcountinhibit CSRs, 3-phase access  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module csr_counter_wr
    import csr_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_req,
    output logic        csr_ready,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        retire,
    output logic        csr_rvalid,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal
);

    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    csr_state_e  state_q;
    logic [11:0] addr_q;
    csr_op_e     op_q;
    logic [31:0] wdata_q;
    logic [31:0] new_q;
    logic        wr_q;
    logic        rvalid_q;
    logic        illegal_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        inh_cy_q;
    logic        inh_ir_q;

    logic [31:0] old_d;
    logic [31:0] new_d;
    logic        legal_d;
    logic        ro_d;
    logic        illegal_d;
    logic        wr_d;

    always_comb begin
        old_d   = '0;
        legal_d = 1'b1;
        ro_d    = 1'b0;
        case (addr_q)
            C_ADDR_MCYCLE:    old_d = cycle_cnt[31:0];
            C_ADDR_MCYCLEH:   old_d = cycle_cnt[63:32];
            C_ADDR_MINSTRET:  old_d = instret_cnt[31:0];
            C_ADDR_MINSTRETH: old_d = instret_cnt[63:32];
            C_ADDR_MCOUNTINH: begin
                old_d[C_INH_CY] = inh_cy_q;
                old_d[C_INH_IR] = inh_ir_q;
            end
            C_ADDR_CYCLE:     begin old_d = cycle_cnt[31:0];    ro_d = 1'b1; end
            C_ADDR_CYCLEH:    begin old_d = cycle_cnt[63:32];   ro_d = 1'b1; end
            C_ADDR_INSTRET:   begin old_d = instret_cnt[31:0];  ro_d = 1'b1; end
            C_ADDR_INSTRETH:  begin old_d = instret_cnt[63:32]; ro_d = 1'b1; end
            default:          legal_d = 1'b0;
        endcase

        case (op_q)
            CSR_RW:  new_d = wdata_q;
            CSR_RS:  new_d = old_d | wdata_q;
            CSR_RC:  new_d = old_d & ~wdata_q;
            default: new_d = old_d;
        endcase

        illegal_d = !legal_d || (ro_d && is_write(op_q, wdata_q));
        wr_d      = !illegal_d && is_write(op_q, wdata_q);
    end

    logic commit_wr;
    assign commit_wr = (state_q == ST_COMMIT) && wr_q;

    csr_cnt64 u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!inh_cy_q),
        .wr_lo (commit_wr && (addr_q == C_ADDR_MCYCLE)),
        .wr_hi (commit_wr && (addr_q == C_ADDR_MCYCLEH)),
        .wdata (new_q),
        .cnt   (cycle_cnt)
    );

    csr_cnt64 u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire && !inh_ir_q),
        .wr_lo (commit_wr && (addr_q == C_ADDR_MINSTRET)),
        .wr_hi (commit_wr && (addr_q == C_ADDR_MINSTRETH)),
        .wdata (new_q),
        .cnt   (instret_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            op_q      <= CSR_READ;
            wdata_q   <= '0;
            new_q     <= '0;
            wr_q      <= 1'b0;
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b1;
            inh_cy_q  <= 1'b0;
            inh_ir_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csr_req) begin
                        addr_q  <= csr_addr;
                        op_q    <= csr_op_e'(csr_op);
                        wdata_q <= csr_wdata;
                        ready_q <= 1'b0;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    new_q     <= new_d;
                    wr_q      <= wr_d;
                    illegal_q <= illegal_d;
                    rdata_q   <= illegal_d ? 32'd0 : old_d;
                    rvalid_q  <= 1'b1;
                    state_q   <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // Inhibit bits take effect from the cycle after COMMIT.
                    if (wr_q && (addr_q == C_ADDR_MCOUNTINH)) begin
                        inh_cy_q <= new_q[C_INH_CY];
                        inh_ir_q <= new_q[C_INH_IR];
                    end
                    wr_q      <= 1'b0;
                    rvalid_q  <= 1'b0;
                    illegal_q <= 1'b0;
                    rdata_q   <= '0;
                    ready_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign csr_ready   = ready_q;
    assign csr_rvalid  = rvalid_q;
    assign csr_rdata   = rdata_q;
    assign csr_illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_counter_wr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_csr_counter_wr : directed table + sequence bench for csr_counter_wr|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_csr_counter_wr;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_req;
    logic        csr_ready;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        retire;
    logic        csr_rvalid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csr_counter_wr #(.CNT_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_req     (csr_req),
        .csr_ready   (csr_ready),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .retire      (retire),
        .csr_rvalid  (csr_rvalid),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal)
    );

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
        bit          chk_rd;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
        n_checks++;
        if ((act < lo) || (act > hi)) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected range 0x%08h..0x%08h", name, act, lo, hi);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the response.
    task automatic do_acc(input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input bit rpulse,
                          output logic [31:0] rd, output logic ill);
        int n = 0;
        rd  = '0;
        ill = 1'b0;
        while (!csr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!csr_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got csr_ready=0 expected 1");
        end else begin
            csr_req   = 1'b1;
            csr_addr  = addr;
            csr_op    = op;
            csr_wdata = wd;
            @(posedge clk);
            @(negedge clk);
            csr_req = 1'b0;
            chk("rvalid_early", {31'd0, csr_rvalid}, 32'd0);
            @(negedge clk);
            chk("rvalid_at_2", {31'd0, csr_rvalid}, 32'd1);
            rd  = csr_rdata;
            ill = csr_illegal;
            if (rpulse) retire = 1'b1;
            @(negedge clk);
            retire = 1'b0;
            chk("rvalid_drop", {29'd0, csr_rvalid, csr_illegal, (csr_rdata != 0)}, 32'd0);
        end
    endtask

    task automatic pulse_retire(input int n);
        for (int k = 0; k < n; k++) begin
            retire = 1'b1;
            @(negedge clk);
            retire = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, b;
        logic        ill;
        bit          bad;

        rst_n = 1'b0; csr_req = 1'b0; csr_addr = '0; csr_op = '0;
        csr_wdata = '0; retire = 1'b0;

        vecs[0]  = '{OP_RW,   12'h320, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1};
        vecs[1]  = '{OP_READ, 12'h320, 32'h0,         32'h0000_0005, 1'b0, 1'b1};
        vecs[2]  = '{OP_RW,   12'hB00, 32'h1234_5678, 32'h0,         1'b0, 1'b0};
        vecs[3]  = '{OP_RW,   12'hB80, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
        vecs[4]  = '{OP_READ, 12'hB00, 32'h0,         32'h1234_5678, 1'b0, 1'b1};
        vecs[5]  = '{OP_READ, 12'hC80, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[6]  = '{OP_RS,   12'hB00, 32'h0000_000F, 32'h1234_5678, 1'b0, 1'b1};
        vecs[7]  = '{OP_READ, 12'hB00, 32'h0,         32'h1234_567F, 1'b0, 1'b1};
        vecs[8]  = '{OP_RC,   12'hB80, 32'hFFFF_0000, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[9]  = '{OP_READ, 12'hC80, 32'h0,         32'h0000_BEEF, 1'b0, 1'b1};
        vecs[10] = '{OP_RW,   12'hB02, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 1'b1};
        vecs[11] = '{OP_RW,   12'hB82, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
        vecs[12] = '{OP_READ, 12'hC02, 32'h0,         32'hAAAA_5555, 1'b0, 1'b1};
        vecs[13] = '{OP_READ, 12'hB82, 32'h0,         32'h0000_0001, 1'b0, 1'b1};
        vecs[14] = '{OP_RW,   12'hC00, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
        vecs[15] = '{OP_READ, 12'h7FF, 32'h0,         32'h0000_0000, 1'b1, 1'b1};
        vecs[16] = '{OP_RS,   12'hC00, 32'h0,         32'h1234_567F, 1'b0, 1'b1};
        vecs[17] = '{OP_RC,   12'hC02, 32'h0,         32'hAAAA_5555, 1'b0, 1'b1};
        vecs[18] = '{OP_RS,   12'hC80, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
        vecs[19] = '{OP_READ, 12'hB00, 32'h0,         32'h1234_567F, 1'b0, 1'b1};
        vecs[20] = '{OP_RW,   12'h320, 32'hFFFF_FFFF, 32'h0000_0005, 1'b0, 1'b1};
        vecs[21] = '{OP_READ, 12'h320, 32'h0,         32'h0000_0005, 1'b0, 1'b1};
        vecs[22] = '{OP_RC,   12'h320, 32'h0000_0004, 32'h0000_0005, 1'b0, 1'b1};
        vecs[23] = '{OP_READ, 12'h320, 32'h0,         32'h0000_0001, 1'b0, 1'b1};

        // Reset values and first read of mcycle after 10 idle cycles.
        repeat (3) @(negedge clk);
        chk("reset_ready",   {31'd0, csr_ready},   32'd1);
        chk("reset_rvalid",  {31'd0, csr_rvalid},  32'd0);
        chk("reset_illegal", {31'd0, csr_illegal}, 32'd0);
        chk("reset_rdata",   csr_rdata,            32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_acc(OP_READ, 12'hB00, 32'h0, 1'b0, rd, ill);
        chk("first_read_ill", {31'd0, ill}, 32'd0);
        chk_range("first_read_mcycle", rd, 32'd10, 32'd12);

        for (int i = 0; i < 24; i++) begin
            do_acc(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b0, rd, ill);
            chk($sformatf("vec%0d_illegal", i), {31'd0, ill}, {31'd0, vecs[i].exp_ill});
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // Both counters inhibited: retire pulses must not move anything.
        do_acc(OP_RS, 12'h320, 32'h4, 1'b0, rd, ill);
        chk("inh_set_old", rd, 32'h1);
        pulse_retire(20);
        do_acc(OP_READ, 12'hB02, 32'h0, 1'b0, rd, ill);
        chk("frozen_minstret", rd, 32'hAAAA_5555);
        do_acc(OP_READ, 12'hB00, 32'h0, 1'b0, rd, ill);
        chk("frozen_mcycle", rd, 32'h1234_567F);
        do_acc(OP_READ, 12'h320, 32'h0, 1'b0, rd, ill);
        chk("inh_read", rd, 32'h5);
        do_acc(OP_RC, 12'h320, 32'h1, 1'b0, rd, ill);
        chk("inh_clr_cy_old", rd, 32'h5);
        do_acc(OP_READ, 12'hB00, 32'h0, 1'b0, a, ill);
        repeat (5) @(negedge clk);
        pulse_retire(3);
        do_acc(OP_READ, 12'hB00, 32'h0, 1'b0, b, ill);
        chk_range("mcycle_resumed_delta", b - a, 32'd1, 32'd30);
        do_acc(OP_READ, 12'hB02, 32'h0, 1'b0, rd, ill);
        chk("minstret_still_frozen", rd, 32'hAAAA_5555);

        // 64-bit wrap of mcycle.
        do_acc(OP_RW, 12'hB80, 32'hFFFF_FFFF, 1'b0, rd, ill);
        do_acc(OP_RW, 12'hB00, 32'hFFFF_FFFF, 1'b0, rd, ill);
        do_acc(OP_READ, 12'hB80, 32'h0, 1'b0, rd, ill);
        chk("wrap_hi", rd, 32'h0);
        do_acc(OP_READ, 12'hB00, 32'h0, 1'b0, rd, ill);
        chk_range("wrap_lo", rd, 32'd2, 32'd4);

        // Retire during COMMIT of a minstret write: the write wins.
        do_acc(OP_RC, 12'h320, 32'h4, 1'b0, rd, ill);
        chk("inh_clr_ir_old", rd, 32'h4);
        do_acc(OP_RW, 12'hB02, 32'h10, 1'b1, rd, ill);
        do_acc(OP_READ, 12'hB02, 32'h0, 1'b0, rd, ill);
        chk("write_wins_retire", rd, 32'h10);
        do_acc(OP_READ, 12'hB82, 32'h0, 1'b0, rd, ill);
        chk("other_half_held", rd, 32'h1);
        pulse_retire(1);
        do_acc(OP_READ, 12'hB02, 32'h0, 1'b0, rd, ill);
        chk("retire_counts", rd, 32'h11);

        // Reset asserted during ACCESS aborts the write and the response.
        csr_req = 1'b1; csr_addr = 12'hB00; csr_op = OP_RW; csr_wdata = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        csr_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("abort_ready", {31'd0, csr_ready}, 32'd1);
        chk("abort_rvalid", {31'd0, csr_rvalid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (csr_rvalid) bad = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_rvalid", {31'd0, bad}, 32'd0);
        do_acc(OP_READ, 12'hB00, 32'h0, 1'b0, rd, ill);
        chk_range("abort_mcycle_lo", rd, 32'd1, 32'd8);
        do_acc(OP_READ, 12'hB80, 32'h0, 1'b0, rd, ill);
        chk("abort_mcycle_hi", rd, 32'h0);
        do_acc(OP_READ, 12'hB02, 32'h0, 1'b0, rd, ill);
        chk("abort_minstret", rd, 32'h0);
        do_acc(OP_READ, 12'h320, 32'h0, 1'b0, rd, ill);
        chk("abort_inhibit", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_counter_wr.md
CSR_COUNTER_WR -- requirements
Module: csr_counter_wr

Interface
REQ-001 SHALL have parameter CNT_W, default 64, meaning counter width (fixed at 64; other values unsupported).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_req  in  1  access request valid.
- csr_ready  out  1  block can accept a request.
- csr_addr  in  12  CSR address.
- csr_op  in  2  00 READ, 01 RW, 10 RS (set), 11 RC (clear).
- csr_wdata  in  32  write/mask operand.
- retire  in  1  one-cycle pulse per retired instruction.
- csr_rvalid  out  1  response valid, one cycle.
- csr_rdata  out  32  old CSR value.
- csr_illegal  out  1  access rejected, qualified by csr_rvalid.

Function
REQ-003 SHALL implement 64-bit mcycle and minstret, plus 32-bit mcountinhibit.
REQ-004 SHALL decode addresses:
- 0xB00/0xB80: mcycle low/high, RW.
- 0xB02/0xB82: minstret low/high, RW.
- 0x320: mcountinhibit, RW; bit0 CY, bit2 IR, all other bits read 0.
- 0xC00/0xC80/0xC02/0xC82: read-only shadows of mcycle/minstret.
REQ-005 SHALL run FSM IDLE -> ACCESS -> COMMIT -> IDLE; csr_ready=1 only in IDLE.
REQ-006 SHALL accept a request on a rising edge where csr_req && csr_ready, latching addr, op and wdata.
REQ-007 SHALL, in ACCESS, capture the old value of the addressed CSR and compute new = wdata (RW), old|wdata (RS), or old&~wdata (RC).
REQ-008 SHALL, in COMMIT, write the new value, drive csr_rvalid=1 and csr_rdata=old, then return to IDLE.
REQ-009 SHALL assert csr_rvalid exactly 2 cycles after the accepting edge, for exactly one cycle.
REQ-010 SHALL perform no write for READ ops, or for RS/RC ops with wdata==0.
REQ-011 SHALL set csr_illegal=1 and csr_rdata=0, with no state change, for:
- an unsupported address, or
- a write op (RW, or RS/RC with wdata!=0) to a 0xCxx address.
REQ-012 SHALL increment mcycle every cycle while mcountinhibit.CY=0.
REQ-013 SHALL increment minstret on each retire pulse while mcountinhibit.IR=0.
REQ-014 SHALL wrap both counters from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-015 SHALL, in the COMMIT cycle of a write to a counter half:
- load that half with the new value;
- hold the other half unchanged;
- suppress that counter's increment in the same cycle (write wins, no carry).
REQ-016 SHALL, when mcountinhibit is written, apply the new inhibit bits starting from the cycle after COMMIT.
REQ-017 SHALL drive csr_rdata=0 and csr_illegal=0 whenever csr_rvalid=0.

Reset
REQ-018 SHALL, while rst_n=0, force:
- FSM to IDLE;
- mcycle, minstret and mcountinhibit to 0;
- csr_rvalid=0, csr_illegal=0, csr_rdata=0, csr_ready=1.
REQ-019 SHALL abort an in-flight access when reset is asserted mid-operation, issuing no response and no commit.
REQ-020 SHALL resume mcycle counting from 0 on the first rising edge after rst_n deasserts.

Structure
REQ-021 SHALL take the following from shared package csr_pkg:
- CSR address constants;
- csr_op_e enum (READ/RW/RS/RC);
- FSM state enum;
- inhibit bit indices.
REQ-022 SHALL instantiate one sub-module, csr_cnt64, twice (cycle and instret). csr_cnt64 has ports clk, rst_n, inc, wr_lo, wr_hi, wdata[31:0], cnt[63:0].

Verification
REQ-023 Reset then idle 10 cycles; READ 0xB00 -> csr_rvalid 2 cycles after accept, csr_rdata = mcycle value at ACCESS, in the range 10..12.
REQ-024 RW 0xB00 wdata=0xFFFF_FFFF after RW 0xB80 wdata=0xFFFF_FFFF:
- next cycle READ 0xB80 shows wrap to 0x0000_0000 within 2 cycles;
- low half resumes from 0.
REQ-025 RS 0x320 wdata=0x5, then 20 retire pulses:
- mcycle and minstret frozen;
- READ 0x320 returns 0x5;
- RC 0x320 wdata=0x1 re-enables mcycle only.
REQ-026 retire pulse in the COMMIT cycle of RW 0xB02 wdata=0x10 -> minstret low reads 0x10, not 0x11.
REQ-027 Illegal accesses:
- RW 0xC00 -> csr_illegal=1, csr_rdata=0, mcycle unaffected;
- READ 0x7FF -> csr_illegal=1;
- RS 0xC00 wdata=0 -> legal read.
REQ-028 rst_n pulsed low during ACCESS of RW 0xB00 wdata=0x1234 -> no csr_rvalid; counters read 0-based afterward; csr_ready=1 immediately.
